led_pulse_gen: RTL

Parametrised multi-channel LED pulse generator for the iCE40 board designs. A shared prescaler and period timer produce a repeating on-window, and each channel applies its own PWM dimming duty inside that window to drive one active-low LED pin. An optional breathe mode ramps each channel's brightness up and down. It sits between the PLL-clocked core and the board LED pins; the per-channel enables come from gating inputs such as IOT pins.

---
 rtl/led_pulse_pkg.sv | 26 ++
 rtl/led_pulse_gen_if.sv | 22 ++
 rtl/led_pulse_chan.sv | 96 +++++++++
 rtl/led_pulse_gen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/led_pulse_pkg.sv
// Shared types and sizing helpers for the LED pulse generator.
// Breathe support is selected by LED_PULSE_BREATHE_EN.
package led_pulse_pkg;

    typedef enum logic {
        MODE_BLINK   = 1'b0,
        MODE_BREATHE = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int MIN_PRESCALE = 2;

    function automatic int prescale_of(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // A modulus of 1 still needs a one-bit register.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/led_pulse_gen_if.sv
// Control and LED bus between the board logic and led_pulse_gen.
// Identical in both the LED_PULSE_BREATHE_EN and blink-only builds.
interface led_pulse_gen_if #(
    parameter int CHANNELS = 2,
    parameter int PWM_BITS = 7
);
    logic [CHANNELS-1:0]          enable;
    logic [CHANNELS*PWM_BITS-1:0] duty;
    logic [CHANNELS-1:0]          mode;
    logic [CHANNELS-1:0]          led_n;
    logic                         period_stb;

    modport master (
        output enable, duty, mode,
        input  led_n, period_stb
    );

    modport slave (
        input  enable, duty, mode,
        output led_n, period_stb
    );
endinterface

// File: rtl/led_pulse_chan.sv
// One LED channel: period-latched duty, optional breathe ramp (LED_PULSE_BREATHE_EN)
// and the registered active-low LED drive.
module led_pulse_chan
    import led_pulse_pkg::*;
#(
    parameter int PWM_BITS = 7
) (
    input  logic                clk,
    input  logic                reset,
`ifdef LED_PULSE_BREATHE_EN
    input  logic                tick,
    input  logic                step_last,
    input  logic                mode_in,
`endif
    input  logic                wrap,
    input  logic                win,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                led_n
);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_n_q, led_n_d;
    logic                lit;

`ifdef LED_PULSE_BREATHE_EN
    mode_e               mode_q, mode_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    dir_e                dir_q, dir_d;
    logic                go_up;

    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        dir_d   = dir_q;
        go_up   = 1'b0;
        if (wrap) begin
            mode_d = mode_e'(mode_in);
        end
        if (mode_q == MODE_BLINK) begin
            level_d = '0;
            dir_d   = DIR_UP;
        end else if (tick && step_last) begin
            // Above the target always heads down; at zero with no target it parks.
            go_up = (level_q < duty_q) && ((dir_q == DIR_UP) || (level_q == '0));
            if (go_up) begin
                level_d = level_q + PWM_BITS'(1);
                dir_d   = (level_q + PWM_BITS'(1) == duty_q) ? DIR_DOWN : DIR_UP;
            end else if (level_q != '0) begin
                level_d = level_q - PWM_BITS'(1);
                dir_d   = (level_q == PWM_BITS'(1)) ? DIR_UP : DIR_DOWN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_BLINK;
            level_q <= '0;
            dir_q   <= DIR_UP;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            dir_q   <= dir_d;
        end
    end
`endif

    always_comb begin
        duty_d = wrap ? duty_in : duty_q;
`ifdef LED_PULSE_BREATHE_EN
        if (mode_q == MODE_BREATHE) begin
            lit = enable && (pwm_cnt < level_q);
        end else begin
            lit = enable && win && (pwm_cnt < duty_q);
        end
`else
        lit = enable && win && (pwm_cnt < duty_q);
`endif
        led_n_d = ~lit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q  <= '0;
            led_n_q <= 1'b1;
        end else begin
            duty_q  <= duty_d;
            led_n_q <= led_n_d;
        end
    end

    assign led_n = led_n_q;

endmodule

// File: rtl/led_pulse_gen.sv
// Multi-channel LED pulse generator: shared prescaler/period/PWM timing feeding
// per-channel dimmers. Define LED_PULSE_BREATHE_EN to compile in breathe mode.
module led_pulse_gen
    import led_pulse_pkg::*;
#(
    parameter int CLK_HZ       = 24_000_000,
    parameter int TICK_HZ      = 100_000,
    parameter int CHANNELS     = 2,
    parameter int PERIOD_TICKS = 100_000,
    parameter int ON_TICKS     = 15_000,
    parameter int PWM_BITS     = 7,
    parameter int STEP_TICKS   = 256
) (
    input  logic            clk,
    input  logic            reset,
    led_pulse_gen_if.slave  bus
);

    localparam int PRESCALE = prescale_of(CLK_HZ, TICK_HZ);
    localparam int PS_W     = cnt_width(PRESCALE);
    localparam int PER_W    = cnt_width(PERIOD_TICKS);

    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_TICKS - 1);
    localparam logic [PER_W-1:0] WIN_START = PER_W'(PERIOD_TICKS - ON_TICKS);

    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_ratio
        $error("led_pulse_gen: CLK_HZ must be a multiple of TICK_HZ");
    end
    if (PRESCALE < MIN_PRESCALE) begin : g_bad_prescale
        $error("led_pulse_gen: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (ON_TICKS < 1 || ON_TICKS > PERIOD_TICKS) begin : g_bad_on
        $error("led_pulse_gen: ON_TICKS must lie in 1..PERIOD_TICKS");
    end
    if (STEP_TICKS < 1) begin : g_bad_step
        $error("led_pulse_gen: STEP_TICKS must be at least 1");
    end

    logic [PS_W-1:0]     prescale_q, prescale_d;
    logic [PER_W-1:0]    period_cnt_q, period_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                period_stb_q, period_stb_d;
    logic                tick, wrap, win;
    logic [CHANNELS-1:0] led_n_w;

    always_comb begin
        tick         = (prescale_q == PS_LAST);
        wrap         = tick && (period_cnt_q == PER_LAST);
        win          = (period_cnt_q >= WIN_START);
        prescale_d   = tick ? '0 : prescale_q + PS_W'(1);
        period_cnt_d = period_cnt_q;
        if (tick) begin
            period_cnt_d = wrap ? '0 : period_cnt_q + PER_W'(1);
        end
        pwm_cnt_d    = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        period_stb_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q   <= '0;
            period_cnt_q <= '0;
            pwm_cnt_q    <= '0;
            period_stb_q <= 1'b0;
        end else begin
            prescale_q   <= prescale_d;
            period_cnt_q <= period_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            period_stb_q <= period_stb_d;
        end
    end

`ifdef LED_PULSE_BREATHE_EN
    localparam int ST_W = cnt_width(STEP_TICKS);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_TICKS - 1);

    logic [ST_W-1:0] step_cnt_q, step_cnt_d;
    logic            step_last;

    always_comb begin
        step_last  = (step_cnt_q == ST_LAST);
        step_cnt_d = step_cnt_q;
        if (tick) begin
            step_cnt_d = step_last ? '0 : step_cnt_q + ST_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_q <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
        end
    end
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_pulse_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
`ifdef LED_PULSE_BREATHE_EN
            .tick      (tick),
            .step_last (step_last),
            .mode_in   (bus.mode[i]),
`endif
            .wrap      (wrap),
            .win       (win),
            .enable    (bus.enable[i]),
            .pwm_cnt   (pwm_cnt_q),
            .duty_in   (bus.duty[i*PWM_BITS +: PWM_BITS]),
            .led_n     (led_n_w[i])
        );
    end

    assign bus.led_n      = led_n_w;
    assign bus.period_stb = period_stb_q;

endmodule
